// File: rtl/nist_stream_tester.sv
// rtl/nist_stream_tester.sv - online monobit, runs and longest-run tester for a serial bit stream
//
// Purpose: consumes one response bit per cycle where i_bit_valid is high and,
// every N_BITS consumed bits, loads snapshot registers with the window's ones
// count, total runs and longest run. It also loads three pass flags and pulses
// o_result_valid for one cycle.
//
// Ports:
//   i_clk           test clock, rising edge
//   i_rst           synchronous active-high reset
//   i_bit_valid     qualifies i_rand
//   i_rand          bit under test
//   o_result_valid  one-cycle pulse, the cycle after a window's last bit
//   o_test_result   [0] frequency, [1] runs, [2] long-run pass; held
//   o_ones_count    ones count of the last completed window
//   o_runs_count    total runs of the last completed window
//   o_longest_run   longest run of the last completed window
//   o_bit_index     bits consumed so far in the current window
module nist_stream_tester #(
    parameter int N_BITS       = 20000,
    parameter int CNT_W        = 15,
    parameter int ONES_MIN     = 9725,
    parameter int ONES_MAX     = 10275,
    parameter int RUNS_MIN     = 9800,
    parameter int RUNS_MAX     = 10200,
    parameter int LONG_RUN_MAX = 25
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit_valid,
    input  logic             i_rand,
    output logic             o_result_valid,
    output logic [2:0]       o_test_result,
    output logic [CNT_W-1:0] o_ones_count,
    output logic [CNT_W-1:0] o_runs_count,
    output logic [CNT_W-1:0] o_longest_run,
    output logic [CNT_W-1:0] o_bit_index
);

    localparam logic [CNT_W-1:0] L_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_N_BITS   = CNT_W'(N_BITS);
    localparam logic [CNT_W-1:0] L_ONES_MIN = CNT_W'(ONES_MIN);
    localparam logic [CNT_W-1:0] L_ONES_MAX = CNT_W'(ONES_MAX);
    localparam logic [CNT_W-1:0] L_RUNS_MIN = CNT_W'(RUNS_MIN);
    localparam logic [CNT_W-1:0] L_RUNS_MAX = CNT_W'(RUNS_MAX);
    localparam logic [CNT_W-1:0] L_LONG_MAX = CNT_W'(LONG_RUN_MAX);

    typedef enum logic {
        S_FIRST,
        S_ACCUM
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_ones;
    logic [CNT_W-1:0] r_runs;
    logic [CNT_W-1:0] r_cur_len;
    logic [CNT_W-1:0] r_longest;
    logic             r_prev_bit;

    logic             w_first;
    logic             w_same;
    logic             w_done;
    logic [CNT_W-1:0] w_rand_ext;
    logic [CNT_W-1:0] w_ones_nxt;
    logic [CNT_W-1:0] w_runs_nxt;
    logic [CNT_W-1:0] w_cur_nxt;
    logic [CNT_W-1:0] w_long_nxt;
    logic [CNT_W-1:0] w_idx_nxt;

    // Values the window would hold after consuming i_rand this cycle. In
    // S_FIRST the stale accumulators of the previous window are ignored.
    always_comb begin
        w_first    = (r_state == S_FIRST);
        w_same     = (i_rand == r_prev_bit);
        w_rand_ext = {{(CNT_W-1){1'b0}}, i_rand};
        w_ones_nxt = w_first ? w_rand_ext : r_ones + w_rand_ext;
        w_runs_nxt = w_first ? L_ONE : (w_same ? r_runs : r_runs + L_ONE);
        w_cur_nxt  = (w_first || !w_same) ? L_ONE : r_cur_len + L_ONE;
        w_long_nxt = w_first ? L_ONE
                   : ((w_cur_nxt > r_longest) ? w_cur_nxt : r_longest);
        w_idx_nxt  = w_first ? L_ONE : o_bit_index + L_ONE;
        w_done     = (w_idx_nxt == L_N_BITS);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_FIRST;
            r_ones         <= '0;
            r_runs         <= '0;
            r_cur_len      <= '0;
            r_longest      <= '0;
            r_prev_bit     <= 1'b0;
            o_result_valid <= 1'b0;
            o_test_result  <= 3'b000;
            o_ones_count   <= '0;
            o_runs_count   <= '0;
            o_longest_run  <= '0;
            o_bit_index    <= '0;
        end else begin
            o_result_valid <= 1'b0;
            if (i_bit_valid) begin
                r_ones     <= w_ones_nxt;
                r_runs     <= w_runs_nxt;
                r_cur_len  <= w_cur_nxt;
                r_longest  <= w_long_nxt;
                r_prev_bit <= i_rand;
                if (w_done) begin
                    // Snapshot includes the closing bit; the next valid bit,
                    // even in the pulse cycle, opens a fresh window.
                    o_ones_count     <= w_ones_nxt;
                    o_runs_count     <= w_runs_nxt;
                    o_longest_run    <= w_long_nxt;
                    o_test_result[0] <= (w_ones_nxt >= L_ONES_MIN) && (w_ones_nxt <= L_ONES_MAX);
                    o_test_result[1] <= (w_runs_nxt >= L_RUNS_MIN) && (w_runs_nxt <= L_RUNS_MAX);
                    o_test_result[2] <= (w_long_nxt <= L_LONG_MAX);
                    o_result_valid   <= 1'b1;
                    o_bit_index      <= '0;
                    r_state          <= S_FIRST;
                end else begin
                    o_bit_index      <= w_idx_nxt;
                    r_state          <= S_ACCUM;
                end
            end
        end
    end

endmodule

// File: doc/nist_stream_tester.md
Name: nist_stream_tester

Overview:
- Online randomness tester that consumes the serial PUF response bit stream, one bit per qualified clock.
- Evaluates three statistics over fixed windows of N_BITS bits: monobit frequency, total runs, and longest run.
- Emits a one-cycle pass/fail result per window, so the test FSM can accumulate per-test pass counts and store them to result memory.
- Sits directly downstream of the response/test-data register in the PUF test path, on the test clock.

Parameters:
- N_BITS, 20000: bits per evaluation window.
- CNT_W, 15: counter width; must satisfy 2^CNT_W > N_BITS.
- ONES_MIN, 9725: minimum ones count that passes the frequency test (inclusive).
- ONES_MAX, 10275: maximum ones count that passes the frequency test (inclusive).
- RUNS_MIN, 9800: minimum total runs that passes the runs test (inclusive).
- RUNS_MAX, 10200: maximum total runs that passes the runs test (inclusive).
- LONG_RUN_MAX, 25: maximum longest-run length that passes the long-run test (inclusive).

Ports:
- clk  input  1  test clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_valid  input  1  qualifies rand; the bit is consumed in any cycle where this is 1.
- rand  input  1  response bit under test.
- result_valid  output  1  one-cycle pulse, asserted when a window completes.
- test_result  output  3  [0] frequency pass, [1] runs pass, [2] long-run pass; held until the next window completes.
- ones_count  output  CNT_W  snapshot of the ones count for the last completed window.
- runs_count  output  CNT_W  snapshot of total runs for the last completed window.
- longest_run  output  CNT_W  snapshot of the longest run for the last completed window.
- bit_index  output  CNT_W  number of bits consumed so far in the current window.

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge only.
  - All outputs and internal state go to 0: result_valid, test_result, ones_count, runs_count, longest_run, bit_index, the internal accumulators, prev_bit and the first flag.
  - rst has priority over bit_valid. A window in progress is discarded with no result_valid, and the next window starts at the first valid bit after rst deasserts.
- States:
  - FIRST: no bit of the window has been consumed yet. On a valid bit: ones = rand, runs = 1, cur_len = 1, longest = 1, prev_bit = rand, index = 1, go to ACCUM.
  - ACCUM: on each valid bit:
    - ones += rand.
    - If rand == prev_bit: cur_len += 1; otherwise runs += 1 and cur_len = 1.
    - longest = max(longest, new cur_len).
    - prev_bit = rand, index += 1.
- Window completion:
  - When the consumed bit makes index equal N_BITS, the snapshot registers and test_result load the final values, including that bit.
  - result_valid goes high in the following cycle, for exactly one cycle, and the FSM returns to FIRST.
  - The first valid bit in the cycle that result_valid is high is bit 0 of the next window. There is no gap, and no bit is dropped at the boundary.
- Pass criteria, computed on the final values:
  - [0] = ONES_MIN <= ones <= ONES_MAX.
  - [1] = RUNS_MIN <= runs <= RUNS_MAX.
  - [2] = longest <= LONG_RUN_MAX.
  - All comparisons are unsigned and inclusive.
- Idle cycles: when bit_valid = 0, all accumulators, prev_bit and state hold; result_valid is still a single pulse.
- Arithmetic: counters never overflow because every count is <= N_BITS < 2^CNT_W. N_BITS = 1 is legal: every window completes on its first bit, with runs = 1 and longest = 1.
- Latency: one cycle from the last valid bit of a window to result_valid.
- bit_index wraps from N_BITS-1 to 0 on completion; it is 0 in the cycle result_valid is high, unless a valid bit is consumed in that cycle, in which case it is 1.

Test Plan (all at default parameters unless stated):
- 20000 valid zeros → ones 0, runs 1, longest 20000, test_result 3'b000, with result_valid pulsed exactly one cycle after the last bit.
- Alternating 0101... for 20000 bits → ones 10000, runs 20000, longest 1, test_result 3'b101.
- Repeating 1100 for 20000 bits → ones 10000, runs 10000, longest 2, test_result 3'b111. Back-to-back windows with bit_valid held high produce identical results every 20000 cycles with no lost bit.
- Frequency boundary:
  - 9725 ones then 10275 zeros → ones 9725, runs 2, test_result 3'b001.
  - 9724 ones then zeros → [0] = 0.
  - 10275 zeros then 10275 ones, at N_BITS = 20550 with ONES_MAX raised → checks the upper boundary.
- Long-run boundary (N_BITS = 52): 26 ones then 26 zeros → longest 26, [2] = 0. 25 ones then 27 zeros → longest 27, [2] = 0. 25 ones, 1 zero, 25 ones, 1 zero → longest 25, [2] = 1.
- Gaps and reset:
  - The 1100 pattern with bit_valid randomly deasserted 50% of the time → same results as the gap-free run.
  - rst asserted at bit 12000 → no result_valid and all outputs 0.
  - A full 20000-bit window after rst deasserts → a correct single result.
